// File: rtl/rv3n_muldiv_issue.sv
// Issue side of the func_muldiv req/ack interface: in-order op queue, in-flight tag FIFO,
// registered register-file writeback and a pending-destination mask for the dispatch scoreboard.
module rv3n_muldiv_issue #(
  parameter int XLEN     = 32,
  parameter int QDEPTH   = 2,
  parameter int INFLIGHT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_para,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_op0,
  input  logic [XLEN-1:0] in_op1,
  input  logic            flush,
  output logic            func_muldiv_req_valid,
  output logic [7:0]      func_muldiv_req_para,
  output logic [12:0]     func_muldiv_req_imm,
  output logic [XLEN-1:0] func_muldiv_req_pc,
  output logic [XLEN-1:0] func_muldiv_req_operand0,
  output logic [XLEN-1:0] func_muldiv_req_operand1,
  input  logic            func_muldiv_ack_valid,
  input  logic [XLEN-1:0] func_muldiv_ack_data,
  input  logic            func_muldiv_ack_busy,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [31:0]     pend_mask,
  output logic            idle,
  output logic            err
);

  localparam int QPW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int QCW = $clog2(QDEPTH) + 1;
  localparam int TPW = (INFLIGHT > 1) ? $clog2(INFLIGHT) : 1;
  localparam int TCW = $clog2(INFLIGHT) + 1;
  localparam logic [QCW-1:0] QFULL = QCW'(QDEPTH);
  localparam logic [TCW-1:0] TFULL = TCW'(INFLIGHT);

  logic [2:0]      q_para_q [QDEPTH];
  logic [4:0]      q_rd_q   [QDEPTH];
  logic [XLEN-1:0] q_pc_q   [QDEPTH];
  logic [XLEN-1:0] q_op0_q  [QDEPTH];
  logic [XLEN-1:0] q_op1_q  [QDEPTH];
  logic [QDEPTH-1:0] q_vld_q;
  logic [QPW-1:0]  q_wptr_q, q_rptr_q, q_wptr_nxt, q_rptr_nxt;
  logic [QCW-1:0]  q_count_q, q_count_d;

  logic [4:0]        t_rd_q [INFLIGHT];
  logic [INFLIGHT-1:0] t_kill_q;
  logic [INFLIGHT-1:0] t_vld_q;
  logic [TPW-1:0]    t_wptr_q, t_rptr_q, t_wptr_nxt, t_rptr_nxt;
  logic [TCW-1:0]    t_count_q, t_count_d;

  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q;
  logic            err_q;

  logic q_push, issue, t_pop;

  assign in_ready = (q_count_q < QFULL);
  assign q_push   = in_valid & in_ready & ~flush;
  assign issue    = (q_count_q != '0) & ~func_muldiv_ack_busy & (t_count_q < TFULL) & ~flush;
  assign t_pop    = func_muldiv_ack_valid & (t_count_q != '0);

  assign q_wptr_nxt = (q_wptr_q == QPW'(QDEPTH - 1)) ? '0 : q_wptr_q + 1'b1;
  assign q_rptr_nxt = (q_rptr_q == QPW'(QDEPTH - 1)) ? '0 : q_rptr_q + 1'b1;
  assign t_wptr_nxt = (t_wptr_q == TPW'(INFLIGHT - 1)) ? '0 : t_wptr_q + 1'b1;
  assign t_rptr_nxt = (t_rptr_q == TPW'(INFLIGHT - 1)) ? '0 : t_rptr_q + 1'b1;

  // Request fields always come from the head slot, which is reset, so they never carry X.
  assign func_muldiv_req_valid    = issue;
  assign func_muldiv_req_para     = {5'b0, q_para_q[q_rptr_q]};
  assign func_muldiv_req_imm      = '0;
  assign func_muldiv_req_pc       = q_pc_q[q_rptr_q];
  assign func_muldiv_req_operand0 = q_op0_q[q_rptr_q];
  assign func_muldiv_req_operand1 = q_op1_q[q_rptr_q];

  always_comb begin
    q_count_d = q_count_q;
    if (flush) begin
      q_count_d = '0;
    end else begin
      q_count_d = q_count_q + QCW'(q_push) - QCW'(issue);
    end
  end

  always_comb begin
    t_count_d = t_count_q + TCW'(issue) - TCW'(t_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_para_q[i] <= '0;
        q_rd_q[i]   <= '0;
        q_pc_q[i]   <= '0;
        q_op0_q[i]  <= '0;
        q_op1_q[i]  <= '0;
      end
      q_vld_q   <= '0;
      q_wptr_q  <= '0;
      q_rptr_q  <= '0;
      q_count_q <= '0;
    end else if (flush) begin
      q_vld_q   <= '0;
      q_wptr_q  <= '0;
      q_rptr_q  <= '0;
      q_count_q <= q_count_d;
    end else begin
      if (q_push) begin
        q_para_q[q_wptr_q] <= in_para;
        q_rd_q[q_wptr_q]   <= in_rd;
        q_pc_q[q_wptr_q]   <= in_pc;
        q_op0_q[q_wptr_q]  <= in_op0;
        q_op1_q[q_wptr_q]  <= in_op1;
        q_vld_q[q_wptr_q]  <= 1'b1;
        q_wptr_q           <= q_wptr_nxt;
      end
      if (issue) begin
        q_vld_q[q_rptr_q] <= 1'b0;
        q_rptr_q          <= q_rptr_nxt;
      end
      q_count_q <= q_count_d;
    end
  end

  // The unit cannot be cancelled, so a flush only marks in-flight tags; their acks still pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < INFLIGHT; i++) begin
        t_rd_q[i] <= '0;
      end
      t_kill_q  <= '0;
      t_vld_q   <= '0;
      t_wptr_q  <= '0;
      t_rptr_q  <= '0;
      t_count_q <= '0;
    end else begin
      if (flush) begin
        t_kill_q <= '1;
      end
      if (issue) begin
        t_rd_q[t_wptr_q]   <= q_rd_q[q_rptr_q];
        t_kill_q[t_wptr_q] <= 1'b0;
        t_vld_q[t_wptr_q]  <= 1'b1;
        t_wptr_q           <= t_wptr_nxt;
      end
      if (t_pop) begin
        t_vld_q[t_rptr_q] <= 1'b0;
        t_rptr_q          <= t_rptr_nxt;
      end
      t_count_q <= t_count_d;
    end
  end

  assign wb_valid_d = t_pop & ~t_kill_q[t_rptr_q] & (t_rd_q[t_rptr_q] != 5'd0) & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      if (wb_valid_d) begin
        wb_rd_q   <= t_rd_q[t_rptr_q];
        wb_data_q <= func_muldiv_ack_data;
      end
      if (func_muldiv_ack_valid && (t_count_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign err      = err_q;
  assign idle     = (q_count_q == '0) & (t_count_q == '0);

  // x0 is never a real hazard, so bit 0 stays clear even if rd=0 ops are outstanding.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (q_vld_q[i]) begin
        pend_mask[q_rd_q[i]] = 1'b1;
      end
    end
    for (int i = 0; i < INFLIGHT; i++) begin
      if (t_vld_q[i] && !t_kill_q[i]) begin
        pend_mask[t_rd_q[i]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

endmodule
